// File: rtl/rcc_test_cfg_loader.sv
// Serial loader for the RCC test-mode clock configuration word.
// Optional even-parity frame bit: define RCC_TCFG_PARITY_EN.
module rcc_test_cfg_loader #(
  parameter int CFG_W = 72,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             atspeed_mode,
  input  logic             cfg_sen,
  input  logic             cfg_sdi,
  input  logic             cfg_cap,
  input  logic             cfg_upd,
  output logic             cfg_sdo,
  output logic             cfg_busy,
  output logic             cfg_err,
  output logic             cfg_done,
  output logic [CFG_W-1:0] test_cfg
);

`ifdef RCC_TCFG_PARITY_EN
  localparam int SR_W = CFG_W + 1;
`else
  localparam int SR_W = CFG_W;
`endif

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SR_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SR_W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] PEND  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic [SR_W-1:0]  sr_shift;
  logic [SR_W-1:0]  cap_img;
  logic [CNT_W-1:0] cnt_inc;
  logic             par_ok;

  assign sr_shift = {cfg_sdi, sr_q[SR_W-1:1]};
  assign cnt_inc  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

`ifdef RCC_TCFG_PARITY_EN
  assign cap_img = {^cfg_q, cfg_q};
  assign par_ok  = (^sr_q) == 1'b0;
`else
  assign cap_img = cfg_q;
  assign par_ok  = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (cfg_cap) begin
          sr_d  = cap_img;
          cnt_d = '0;
        end else if (cfg_upd) begin
          err_d = 1'b1;
          cnt_d = '0;
        end else if (cfg_sen) begin
          sr_d    = sr_shift;
          cnt_d   = cnt_inc;
          state_d = SHIFT;
        end
      end
      (state_q == SHIFT): begin
        if (cfg_cap) begin
          sr_d    = cap_img;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cfg_upd) begin
          state_d = CHECK;
        end else if (cfg_sen) begin
          sr_d  = sr_shift;
          cnt_d = cnt_inc;
        end
      end
      (state_q == CHECK): begin
        if (cnt_q == CNT_FULL && par_ok) begin
          state_d = PEND;
        end else begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      // Held here through at-speed capture so the muxed config stays put
      (state_q == PEND): begin
        if (!atspeed_mode) begin
          cfg_d   = sr_q[CFG_W-1:0];
          done_d  = 1'b1;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      cfg_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign cfg_sdo  = sr_q[0];
  assign cfg_busy = (state_q == PEND);
  assign cfg_err  = err_q;
  assign cfg_done = done_q;
  assign test_cfg = cfg_q;

endmodule

// File: tb/tb_rcc_test_cfg_loader.sv
// Scoreboard bench for rcc_test_cfg_loader.
// Parity scenario runs when RCC_TCFG_PARITY_EN is defined.
module tb_rcc_test_cfg_loader;

`ifdef RCC_TCFG_PARITY_EN
  localparam int SRW = 73;
`else
  localparam int SRW = 72;
`endif

  localparam logic [71:0] IMG1 = 72'hA5_0123456789ABCDEF;
  localparam logic [71:0] IMG2 = 72'h3C_FEDCBA9876543210;
  localparam logic [71:0] IMG3 = 72'h5A_C3C3C3C30F0F0F0F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        atspeed_mode;
  logic        cfg_sen;
  logic        cfg_sdi;
  logic        cfg_cap;
  logic        cfg_upd;
  logic        cfg_sdo;
  logic        cfg_busy;
  logic        cfg_err;
  logic        cfg_done;
  logic [71:0] test_cfg;

  int tests = 0;
  int fails = 0;
  logic [71:0] cur_cfg;
  logic [71:0] exp_q[$];
  logic        bit_q[$];

  rcc_test_cfg_loader dut (
    .clk(clk), .rst_n(rst_n), .atspeed_mode(atspeed_mode),
    .cfg_sen(cfg_sen), .cfg_sdi(cfg_sdi), .cfg_cap(cfg_cap),
    .cfg_upd(cfg_upd), .cfg_sdo(cfg_sdo), .cfg_busy(cfg_busy),
    .cfg_err(cfg_err), .cfg_done(cfg_done), .test_cfg(test_cfg)
  );

  always #5 clk = ~clk;

  function automatic logic [72:0] frame(input logic [71:0] d);
`ifdef RCC_TCFG_PARITY_EN
    return {^d, d};
`else
    return {1'b0, d};
`endif
  endfunction

  task automatic shift_frame(input logic [72:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cfg_sen = 1'b1;
      cfg_sdi = fr[i];
    end
    @(negedge clk);
    cfg_sen = 1'b0;
    cfg_sdi = 1'b0;
  endtask

  task automatic pulse_cap();
    @(negedge clk);
    cfg_cap = 1'b1;
    @(negedge clk);
    cfg_cap = 1'b0;
  endtask

  task automatic pulse_upd(input logic [71:0] img, input bit good);
    @(negedge clk);
    cfg_upd = 1'b1;
    if (good) exp_q.push_back(img);
    @(negedge clk);
    cfg_upd = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int lat);
    logic [71:0] e;
    lat = 0;
    while (lat < maxc) begin
      @(negedge clk);
      lat++;
      if (cfg_done) break;
    end
    tests++;
    if (!cfg_done) begin
      fails++;
      $display("FAIL done_timeout got=0 want=1");
    end else if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL sb_empty got=%h want=none", test_cfg);
    end else begin
      e = exp_q.pop_front();
      cur_cfg = e;
      if (test_cfg !== e) begin
        fails++;
        $display("FAIL sb_cfg got=%h want=%h", test_cfg, e);
      end
    end
  endtask

  task automatic test_reset();
    tests++;
    if (test_cfg !== 72'h0 || cfg_err !== 1'b0 || cfg_busy !== 1'b0 ||
        cfg_sdo !== 1'b0 || cfg_done !== 1'b0) begin
      fails++;
      $display("FAIL reset cfg=%h err=%b busy=%b sdo=%b done=%b want 0",
               test_cfg, cfg_err, cfg_busy, cfg_sdo, cfg_done);
    end
  endtask

  task automatic test_commit(input logic [71:0] img);
    int lat;
    pulse_cap();
    shift_frame(frame(img), SRW);
    pulse_upd(img, 1'b1);
    wait_done(8, lat);
    tests++;
    if (lat !== 2) begin
      fails++;
      $display("FAIL commit_latency got=%0d want=2", lat);
    end
    tests++;
    if (test_cfg[1:0] !== img[1:0]) begin
      fails++;
      $display("FAIL pllsrc got=%b want=%b", test_cfg[1:0], img[1:0]);
    end
    @(negedge clk);
    tests++;
    if (cfg_done !== 1'b0 || cfg_err !== 1'b0 || cfg_busy !== 1'b0) begin
      fails++;
      $display("FAIL post_commit done=%b err=%b busy=%b want 0 0 0",
               cfg_done, cfg_err, cfg_busy);
    end
  endtask

  task automatic test_idle_upd();
    pulse_cap();
    pulse_upd(72'h0, 1'b0);
    tests++;
    if (cfg_err !== 1'b1 || test_cfg !== cur_cfg) begin
      fails++;
      $display("FAIL idle_upd err=%b cfg=%h want 1 %h",
               cfg_err, test_cfg, cur_cfg);
    end
  endtask

  task automatic test_atspeed(input logic [71:0] img);
    int bad;
    int lat;
    bad = 0;
    pulse_cap();
    shift_frame(frame(img), SRW);
    atspeed_mode = 1'b1;
    pulse_upd(img, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cfg_busy !== 1'b1 || test_cfg !== cur_cfg || cfg_done !== 1'b0)
        bad++;
      cfg_sen = i[0];
      cfg_sdi = 1'b1;
      cfg_cap = (i == 10);
      cfg_upd = (i == 20);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL atspeed_hold got=%0d bad cycles want=0", bad);
    end
    @(negedge clk);
    cfg_sen = 1'b0;
    cfg_sdi = 1'b0;
    cfg_cap = 1'b0;
    cfg_upd = 1'b0;
    atspeed_mode = 1'b0;
    wait_done(4, lat);
    tests++;
    if (lat !== 1) begin
      fails++;
      $display("FAIL atspeed_release got=%0d want=1", lat);
    end
  endtask

  task automatic test_bad_count(input logic [71:0] img);
    int lat;
    pulse_cap();
    shift_frame(frame(img), SRW - 1);
    pulse_upd(img, 1'b0);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (cfg_err !== 1'b1 || test_cfg !== cur_cfg || cfg_busy !== 1'b0) begin
      fails++;
      $display("FAIL short_load err=%b cfg=%h busy=%b want 1 %h 0",
               cfg_err, test_cfg, cfg_busy, cur_cfg);
    end
    pulse_cap();
    shift_frame(frame(img), SRW);
    pulse_upd(img, 1'b1);
    wait_done(8, lat);
    tests++;
    if (cfg_err !== 1'b0) begin
      fails++;
      $display("FAIL err_clear got=%b want=0", cfg_err);
    end
  endtask

  task automatic test_readback();
    logic [71:0] got;
    logic [71:0] want;
    pulse_cap();
    for (int i = 0; i < 72; i++) bit_q.push_back(cur_cfg[i]);
    for (int i = 0; i < 72; i++) begin
      @(negedge clk);
      got[i]  = cfg_sdo;
      want[i] = bit_q.pop_front();
      cfg_sen = 1'b1;
      cfg_sdi = 1'b0;
    end
    @(negedge clk);
    cfg_sen = 1'b0;
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL readback got=%h want=%h", got, want);
    end
  endtask

`ifdef RCC_TCFG_PARITY_EN
  task automatic test_parity(input logic [71:0] img);
    logic [72:0] fr;
    int lat;
    fr = frame(img);
    fr[72] = ~fr[72];
    pulse_cap();
    shift_frame(fr, SRW);
    pulse_upd(img, 1'b0);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (cfg_err !== 1'b1 || test_cfg !== cur_cfg) begin
      fails++;
      $display("FAIL parity_bad err=%b cfg=%h want 1 %h",
               cfg_err, test_cfg, cur_cfg);
    end
    pulse_cap();
    shift_frame(frame(img), SRW);
    pulse_upd(img, 1'b1);
    wait_done(8, lat);
    tests++;
    if (cfg_err !== 1'b0) begin
      fails++;
      $display("FAIL parity_good err=%b want=0", cfg_err);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int seen;
    pulse_cap();
    shift_frame(frame(IMG3), 30);
    @(negedge clk);
    cfg_sen = 1'b1;
    cfg_sdi = 1'b1;
    rst_n = 1'b0;
    cur_cfg = '0;
    #1;
    test_reset();
    @(negedge clk);
    cfg_sen = 1'b0;
    rst_n = 1'b1;
    shift_frame(frame(IMG1), SRW);
    atspeed_mode = 1'b1;
    pulse_upd(IMG1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    atspeed_mode = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cfg_done || test_cfg !== 72'h0) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL pend_reset got=%0d commits want=0", seen);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    atspeed_mode = 1'b0;
    cfg_sen = 1'b0;
    cfg_sdi = 1'b0;
    cfg_cap = 1'b0;
    cfg_upd = 1'b0;
    cur_cfg = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_commit(IMG1);
    test_idle_upd();
    test_atspeed(IMG2);
    test_bad_count(IMG3);
    test_readback();
`ifdef RCC_TCFG_PARITY_EN
    test_parity(IMG1);
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
